fft_in_packer: RTL
==================

Name: fft_in_packer

Overview:
- Serial-to-parallel front end of the 16-lane pipelined FFT.
- Accepts one complex sample per clock, or fewer with gaps, and assembles 16-sample vectors.
- Presents each completed vector to the FFT first stage as in_i/in_q[0:15] with a one-cycle din_valid strobe.
- Tracks vector position within a POINTS-point frame and flags frame boundaries for the downstream CBFP and control logic.

Parameters:
- WIDTH, 9: sample width, signed, per I and Q.
- LANES, 16: samples per output vector.
- POINTS, 512: points per FFT frame; must be a multiple of LANES, so 32 vectors per frame.

Ports:
- clk  input  1  system clock.
- rstn  input  1  synchronous, active-high reset.
- s_i  input  WIDTH signed  serial sample, real part.
- s_q  input  WIDTH signed  serial sample, imaginary part.
- s_valid  input  1  sample is valid this cycle.
- s_last  input  1  this sample ends the frame early; qualified by s_valid.
- in_i  output  WIDTH signed [0:LANES-1]  packed vector, real part; lane 0 is the earliest sample.
- in_q  output  WIDTH signed [0:LANES-1]  packed vector, imaginary part.
- din_valid  output  1  one-cycle strobe, vector valid.
- frame_start  output  1  asserted with din_valid on vector 0 of a frame.
- frame_end  output  1  asserted with din_valid on the last vector of a frame.

Behaviour:
- Reset: while rstn is high at a clk edge, all outputs clear to 0, lane counter and vector counter clear to 0, and the shift buffer clears to 0.
- No backpressure. The downstream FFT always accepts. s_valid may be asserted on every cycle indefinitely.
- Lane counter (0..LANES-1):
  - Each accepted sample is written to buffer lane [lane_cnt], then lane_cnt increments.
  - When lane_cnt == LANES-1 and a sample is accepted, the full vector (including the current sample) transfers to the output registers on that edge.
  - din_valid is high for exactly the following cycle; lane_cnt wraps to 0.
- Latency: din_valid rises one clk after the edge that accepts the 16th sample.
- Output hold: in_i/in_q hold the last vector until the next transfer. Back-to-back vectors every 16 cycles are supported with no dead cycle; the buffer refills while the outputs hold.
- Gaps: cycles with s_valid=0 do not advance any counter and emit nothing.
- Vector counter (0..POINTS/LANES-1):
  - Increments on each emitted vector and wraps to 0 after the last one.
  - frame_start = (vec_cnt == 0) at emit; frame_end = (vec_cnt == POINTS/LANES-1) at emit.
- s_last with s_valid:
  - The current sample is placed in lane [lane_cnt].
  - Lanes above it are zero-filled in the emitted vector.
  - The vector emits immediately with frame_end=1.
  - lane_cnt and vec_cnt both reset to 0, so the next vector carries frame_start.
- s_last with s_valid=0 is ignored.
- s_last on lane 15 of the final vector is identical to the natural frame end.
- Reset asserted mid-vector or mid-frame discards partial data. No din_valid is produced for the partial vector.
- Purely data-moving: no arithmetic on samples (except under the optional feature below).

Optional Feature:
- Macro: FFT_IN_CONJ_EN.
- When defined:
  - Adds input port fft_mode (1 bit). It is sampled with each accepted sample.
  - When fft_mode=1, the stored Q value is -s_q, saturated to WIDTH bits. -(-256) yields +255 for WIDTH=9. This provides the IFFT conjugate-input path.
  - When fft_mode=0, the stored Q value is s_q.
- When undefined: the port is absent and Q passes unmodified.

Decomposition:
- Shared FFT package holds:
  - constants LANES and POINTS;
  - VEC_PER_FRAME = POINTS/LANES;
  - typedef for a signed WIDTH-bit sample;
  - typedef for a LANES-wide sample array.
- One natural sub-module: fft_in_lane_buf. It holds the LANES-deep indexed buffer with zero-fill-above-index on flush. The parent owns the counters and frame flags.

Test Plan:
- Reset then 512 continuous samples with s_i=n, s_q=-n → 32 din_valid pulses exactly 16 cycles apart, each 1 cycle after its 16th sample. First vector in_i={0..15}; frame_start only on vector 0; frame_end only on vector 31.
- Same stream with s_valid toggled 1,0,1,0… → identical vector contents, pulses 32 cycles apart, no spurious din_valid during gaps.
- 37 samples, s_last on sample 36 (lane 4 of vector 2) → vector 2 holds lanes 0-4 = 32..36 and lanes 5-15 = 0, with frame_end=1. The next vector has frame_start=1.
- rstn high for 1 cycle after 10 samples of a vector → all outputs 0. The next 16 samples form a fresh vector with frame_start=1, and the pre-reset samples are absent.
- Two frames back-to-back (1024 samples) → vec_cnt wraps, and frame_start is asserted on vectors 0 and 32.
- FFT_IN_CONJ_EN, fft_mode=1, s_q ∈ {-256, 255, 0, -1} → stored Q {255, -255, 0, 1}.

Source files
------------

// File: rtl/fft_in_packer_pkg.sv
// Shared constants and sample types for the 16-lane FFT input front end.
package fft_in_packer_pkg;

  localparam int WIDTH         = 9;
  localparam int LANES         = 16;
  localparam int POINTS        = 512;
  localparam int VEC_PER_FRAME = POINTS / LANES;
  localparam int LANE_W        = $clog2(LANES);
  localparam int VEC_W         = $clog2(VEC_PER_FRAME);

  // One signed component (I or Q) of a complex sample.
  typedef logic signed [WIDTH-1:0] sample_t;

  // One full vector of a single component; lane 0 is the earliest sample.
  typedef sample_t [0:LANES-1] sample_vec_t;

endpackage

// File: rtl/fft_in_lane_buf.sv
// LANES-deep indexed sample buffer. The flush view merges the sample being
// written this cycle into its lane and zero-fills every lane above it, so a
// short (s_last) vector leaves no stale data from an earlier vector.
import fft_in_packer_pkg::*;

module fft_in_lane_buf (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [LANE_W-1:0] wr_idx,
  input  sample_t           wr_i,
  input  sample_t           wr_q,
  output sample_vec_t       flush_i,
  output sample_vec_t       flush_q
);

  sample_vec_t buf_i_q, buf_i_d;
  sample_vec_t buf_q_q, buf_q_d;

  // Write the accepted sample into its lane; other lanes hold.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path leaves it unassigned (no latch).
    buf_i_d = buf_i_q;
    buf_q_d = buf_q_q;
    if (wr_en) begin
      buf_i_d[wr_idx] = wr_i;
      buf_q_d[wr_idx] = wr_q;
    end
  end

  // Buffer storage register.
  always_ff @(posedge clk) begin
    // NOTE: this buffer is small flop storage that must read back as zero after reset, so it is reset like any other state.
    if (rstn) begin
      buf_i_q <= '0;
      buf_q_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      buf_i_q <= buf_i_d;
      buf_q_q <= buf_q_d;
    end
  end

  // Vector as it would be emitted if this cycle flushes.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      if (LANE_W'(l) < wr_idx) begin
        flush_i[l] = buf_i_q[l];
        flush_q[l] = buf_q_q[l];
      end else if (LANE_W'(l) == wr_idx) begin
        flush_i[l] = wr_i;
        flush_q[l] = wr_q;
      end else begin
        flush_i[l] = '0;
        flush_q[l] = '0;
      end
    end
  end

endmodule

// File: rtl/fft_in_packer.sv
// Serial-to-parallel front end of the 16-lane FFT: packs one complex sample
// per accepted cycle into LANES-wide vectors, emits each with a one-cycle
// din_valid strobe and tracks the vector position within a POINTS frame.
// Optional macro FFT_IN_CONJ_EN adds fft_mode, which stores the saturated
// negation of s_q (conjugate input for the IFFT).
import fft_in_packer_pkg::*;

module fft_in_packer (
  input  logic                    clk,
  input  logic                    rstn,
`ifdef FFT_IN_CONJ_EN
  input  logic                    fft_mode,
`endif
  input  logic signed [WIDTH-1:0] s_i,
  input  logic signed [WIDTH-1:0] s_q,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic signed [WIDTH-1:0] in_i [0:LANES-1],
  output logic signed [WIDTH-1:0] in_q [0:LANES-1],
  output logic                    din_valid,
  output logic                    frame_start,
  output logic                    frame_end
);

  logic [LANE_W-1:0] lane_cnt_q, lane_cnt_d;
  logic [VEC_W-1:0]  vec_cnt_q, vec_cnt_d;
  sample_vec_t       in_i_q, in_i_d;
  sample_vec_t       in_q_q, in_q_d;
  logic              din_valid_q, din_valid_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_end_q, frame_end_d;

  sample_t           wr_q_val;
  sample_vec_t       flush_i, flush_q;
  logic              emit;
  logic              vec_last;

`ifdef FFT_IN_CONJ_EN
  localparam sample_t Q_MIN = sample_t'({1'b1, {(WIDTH-1){1'b0}}});
  localparam sample_t Q_MAX = sample_t'({1'b0, {(WIDTH-1){1'b1}}});

  // Conjugate path: negate Q with saturation, since -Q_MIN does not fit.
  always_comb begin
    wr_q_val = s_q;
    if (fft_mode) wr_q_val = (s_q == Q_MIN) ? Q_MAX : -s_q;
  end
`else
  // Q passes through unmodified.
  always_comb wr_q_val = s_q;
`endif

  fft_in_lane_buf u_lane_buf (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (s_valid),
    .wr_idx  (lane_cnt_q),
    .wr_i    (s_i),
    .wr_q    (wr_q_val),
    .flush_i (flush_i),
    .flush_q (flush_q)
  );

  // Counter advance, vector emit and frame flag generation.
  always_comb begin
    lane_cnt_d    = lane_cnt_q;
    vec_cnt_d     = vec_cnt_q;
    in_i_d        = in_i_q;
    in_q_d        = in_q_q;
    din_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;

    vec_last = (vec_cnt_q == VEC_W'(VEC_PER_FRAME - 1));
    emit     = s_valid && ((lane_cnt_q == LANE_W'(LANES - 1)) || s_last);

    if (emit) begin
      in_i_d        = flush_i;
      in_q_d        = flush_q;
      din_valid_d   = 1'b1;
      frame_start_d = (vec_cnt_q == '0);
      frame_end_d   = vec_last || s_last;
      lane_cnt_d    = '0;
      // An early s_last closes the frame, so the next vector starts one.
      vec_cnt_d     = (vec_last || s_last) ? '0 : vec_cnt_q + 1'b1;
    end else if (s_valid) begin
      lane_cnt_d    = lane_cnt_q + 1'b1;
    end
  end

  // Counter and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rstn) begin
      lane_cnt_q    <= '0;
      vec_cnt_q     <= '0;
      in_i_q        <= '0;
      in_q_q        <= '0;
      din_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      lane_cnt_q    <= lane_cnt_d;
      vec_cnt_q     <= vec_cnt_d;
      in_i_q        <= in_i_d;
      in_q_q        <= in_q_d;
      din_valid_q   <= din_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
    end
  end

  // Unpack the registered vectors onto the lane ports.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      in_i[l] = in_i_q[l];
      in_q[l] = in_q_q[l];
    end
  end

  assign din_valid   = din_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;

endmodule
